// File: rtl/platform_scroller.sv
// Per-frame scroller for the VGA raster stage: a platform band that scrolls down
// and wraps to the top, and a hole span that ping-pongs across the active width.
module platform_scroller #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int PLAT_TOP    = 400,
  parameter int PLAT_WRAP   = 0,
  parameter int PLAT_H      = 16,
  parameter int HOLE_W      = 64,
  parameter int HOLE_SPEED  = 2,
  parameter int SCROLL_STEP = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       start,
  input  logic       pause,
  input  logic       scroll_en,
  output logic [9:0] plataform_start,
  output logic [9:0] plataform_end,
  output logic [9:0] hole_start,
  output logic [9:0] hole_end,
  output logic [7:0] level,
  output logic       wrap,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE_R = 2'd1,
    MOVE_L = 2'd2,
    PAUSE  = 2'd3
  } state_t;

  localparam logic [10:0] HR11  = 11'(H_ACTIVE - HOLE_W);
  localparam logic [10:0] VL11  = 11'(V_ACTIVE - PLAT_H);
  localparam logic [10:0] HS11  = 11'(HOLE_SPEED);
  localparam logic [10:0] SS11  = 11'(SCROLL_STEP);
  localparam logic [9:0]  HR10  = 10'(H_ACTIVE - HOLE_W);
  localparam logic [9:0]  HS10  = 10'(HOLE_SPEED);
  localparam logic [9:0]  HW10  = 10'(HOLE_W);
  localparam logic [9:0]  PH10  = 10'(PLAT_H);
  localparam logic [9:0]  TOP10 = 10'(PLAT_TOP);
  localparam logic [9:0]  WR10  = 10'(PLAT_WRAP);

  state_t      state_q, state_d;
  logic        dir_q, dir_d;        // 0 = right, 1 = left
  logic        vsync_d;
  logic        tick;
  logic        moving;
  logic [10:0] hole_sum, plat_sum;
  logic [9:0]  hole_d, plat_d;
  logic [7:0]  level_d;
  logic        wrap_d;

  // Falling edge of vsync marks one frame; a held-low vsync yields a single tick.
  assign tick     = vsync_d & ~vsync;
  assign hole_sum = {1'b0, hole_start} + HS11;
  assign plat_sum = {1'b0, plataform_start} + SS11;
  assign state_o  = state_q;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    hole_d  = hole_start;
    plat_d  = plataform_start;
    level_d = level;
    wrap_d  = 1'b0;
    moving  = tick & ~pause & ((state_q == MOVE_R) | (state_q == MOVE_L));

    case (state_q)
      IDLE: begin
        if (start) state_d = dir_q ? MOVE_L : MOVE_R;
      end
      MOVE_R: begin
        if (pause) begin
          state_d = PAUSE;
        end else if (tick) begin
          if (hole_sum >= HR11) begin
            hole_d  = HR10;
            dir_d   = 1'b1;
            state_d = MOVE_L;
          end else begin
            hole_d = hole_sum[9:0];
          end
        end
      end
      MOVE_L: begin
        if (pause) begin
          state_d = PAUSE;
        end else if (tick) begin
          if ({1'b0, hole_start} <= HS11) begin
            hole_d  = 10'd0;
            dir_d   = 1'b0;
            state_d = MOVE_R;
          end else begin
            hole_d = hole_start - HS10;
          end
        end
      end
      PAUSE: begin
        if (!pause) state_d = dir_q ? MOVE_L : MOVE_R;
      end
      default: state_d = IDLE;
    endcase

    // Platform scroll shares the motion qualifier but is further gated by scroll_en.
    if (moving && scroll_en) begin
      if (plat_sum > VL11) begin
        plat_d  = WR10;
        wrap_d  = 1'b1;
        level_d = (level == 8'hff) ? level : level + 8'd1;
      end else begin
        plat_d = plat_sum[9:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= IDLE;
      dir_q           <= 1'b0;
      vsync_d         <= 1'b1;
      plataform_start <= TOP10;
      plataform_end   <= TOP10 + PH10;
      hole_start      <= 10'd0;
      hole_end        <= HW10;
      level           <= 8'd0;
      wrap            <= 1'b0;
    end else begin
      state_q         <= state_d;
      dir_q           <= dir_d;
      vsync_d         <= vsync;
      plataform_start <= plat_d;
      plataform_end   <= plat_d + PH10;
      hole_start      <= hole_d;
      hole_end        <= hole_d + HW10;
      level           <= level_d;
      wrap            <= wrap_d;
    end
  end

endmodule

// File: tb/tb_platform_scroller.sv
// Randomized bench for platform_scroller: a frame-level reference model pushes
// expected output snapshots, a separate monitor pops and compares them.
module tb_platform_scroller;

  localparam int W = 83;  // {check cycle[31:0], ps, pe, hs, he, level, wrap, state}

  logic       clk = 1'b0;
  logic       reset, vsync, start, pause, scroll_en;
  logic [9:0] plataform_start, plataform_end, hole_start, hole_end;
  logic [7:0] level;
  logic       wrap;
  logic [1:0] state_o;

  logic [W-1:0] exp_q[$];
  logic [31:0]  cyc = 32'd0;
  int tests  = 0;
  int failed = 0;

  // Reference model state (spec-level values: state 0 IDLE,1 R,2 L,3 PAUSE; dir 0 right)
  int m_plat, m_hole, m_level, m_state, m_dir, m_wrap, m_vs;

  platform_scroller dut (
    .clk(clk), .reset(reset), .vsync(vsync), .start(start), .pause(pause),
    .scroll_en(scroll_en), .plataform_start(plataform_start),
    .plataform_end(plataform_end), .hole_start(hole_start), .hole_end(hole_end),
    .level(level), .wrap(wrap), .state_o(state_o)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic model_cycle(input logic r, input logic v, input logic s,
                             input logic p, input logic e);
    int tick;
    int nst;
    tick   = (m_vs == 1 && v == 1'b0) ? 1 : 0;
    m_wrap = 0;
    if (!r) begin
      m_plat = 400; m_hole = 0; m_level = 0; m_state = 0; m_dir = 0; m_vs = 1;
      return;
    end
    m_vs = v;
    nst  = m_state;
    if (m_state == 0) begin
      if (s) nst = m_dir ? 2 : 1;
    end else if (m_state == 3) begin
      if (!p) nst = m_dir ? 2 : 1;
    end else if (p) begin
      nst = 3;
    end else if (tick) begin
      if (m_state == 1) begin
        if (m_hole + 2 >= 576) begin m_hole = 576; m_dir = 1; nst = 2; end
        else m_hole += 2;
      end else begin
        if (m_hole <= 2) begin m_hole = 0; m_dir = 0; nst = 1; end
        else m_hole -= 2;
      end
      if (e) begin
        if (m_plat + 1 > 464) begin
          m_plat = 0; m_wrap = 1;
          if (m_level < 255) m_level++;
        end else m_plat++;
      end
    end
    m_state = nst;
  endtask

  // Driver: called at a negedge; inputs take effect at the next posedge.
  task automatic drive(input logic r, input logic v, input logic s,
                       input logic p, input logic e);
    reset = r; vsync = v; start = s; pause = p; scroll_en = e;
    model_cycle(r, v, s, p, e);
    exp_q.push_back({cyc + 32'd1, 10'(m_plat), 10'(m_plat + 16), 10'(m_hole),
                     10'(m_hole + 64), 8'(m_level), 1'(m_wrap), 2'(m_state)});
    @(negedge clk);
  endtask

  task automatic pulse(input int low, input int high, input logic p, input logic e);
    repeat (low)  drive(1'b1, 1'b0, 1'b0, p, e);
    repeat (high) drive(1'b1, 1'b1, 1'b0, p, e);
  endtask

  // Scoreboard monitor
  initial begin
    logic [W-1:0]  rec;
    logic [W-33:0] act;
    forever begin
      @(negedge clk);
      #1;
      while (exp_q.size() > 0 && exp_q[0][W-1:W-32] <= cyc) begin
        rec = exp_q.pop_front();
        act = {plataform_start, plataform_end, hole_start, hole_end, level, wrap, state_o};
        tests++;
        if (act !== rec[W-33:0]) begin
          failed++;
          $display("FAIL outputs cyc=%0d got ps=%0d pe=%0d hs=%0d he=%0d lvl=%0d wrap=%0d st=%0d required ps=%0d pe=%0d hs=%0d he=%0d lvl=%0d wrap=%0d st=%0d",
                   cyc, plataform_start, plataform_end, hole_start, hole_end, level, wrap, state_o,
                   rec[50:41], rec[40:31], rec[30:21], rec[20:11], rec[10:3], rec[2], rec[1:0]);
        end
      end
    end
  end

  initial begin
    int guard;
    m_vs = 1;
    reset = 1'b0; vsync = 1'b1; start = 1'b0; pause = 1'b0; scroll_en = 1'b0;
    @(negedge clk);

    // Reset with random inputs, then idle vsync pulses
    repeat (3) drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++)
      pulse($urandom_range(1, 3), $urandom_range(1, 4), 1'($urandom), 1'($urandom));

    // Start, five frames of motion, then a long low vsync
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) pulse($urandom_range(1, 3), $urandom_range(1, 4), 1'b0, 1'b1);
    pulse(100, 2, 1'b0, 1'b1);

    // Scroll disabled: hole moves, platform holds
    for (int i = 0; i < 20; i++) pulse(1, $urandom_range(1, 3), 1'b0, 1'b0);

    // Long randomized run: bounces, wraps, occasional pauses, start ignored
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 15) == 0) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      pulse($urandom_range(1, 3), $urandom_range(1, 4),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
    end

    // Pause coinciding with a tick while moving left
    guard = 0;
    while (m_state != 2 && guard < 400) begin pulse(1, 1, 1'b0, 1'b1); guard++; end
    tests++;
    if (m_state != 2) begin
      failed++;
      $display("FAIL reach_move_l got state=%0d required 2", m_state);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) pulse(1, 2, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) pulse(1, 2, 1'b0, 1'b1);

    // Reset arriving on the very cycle of a wrap tick
    guard = 0;
    while (!(m_plat == 464 && (m_state == 1 || m_state == 2)) && guard < 600) begin
      pulse(1, 1, 1'b0, 1'b1); guard++;
    end
    tests++;
    if (m_plat != 464) begin
      failed++;
      $display("FAIL reach_wrap_point got plat=%0d required 464", m_plat);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
